// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall sequencer: load-use detection, branch flush, and mult/div run control
// from the DX stage with a timeout that forces completion with an exception code.
module pipeline_stall_controller #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned MUL_EXC    = 4,
  parameter int unsigned DIV_EXC    = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FDinsn,
  input  logic [31:0] DXinsn,
  input  logic        branch_taken,
  input  logic        multdiv_resultRDY,
  input  logic        multdiv_exception,
  input  logic [31:0] multdiv_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall_PC,
  output logic        stall_FD,
  output logic        stall_DX,
  output logic        bubble_DX,
  output logic        bubble_XM,
  output logic        flush_FD,
  output logic        md_valid,
  output logic [31:0] md_result,
  output logic [31:0] md_exception,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(MD_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic [31:0]     md_result_q, md_result_d;
  logic [31:0]     md_exc_q, md_exc_d;

  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic       dx_lw, dx_mul, dx_div;
  logic       fd_r, fd_rs_use, fd_rd_use;
  logic       load_use;
  logic       start, stalled;
  logic [31:0] op_exc;

  assign dx_op    = DXinsn[31:27];
  assign dx_rd    = DXinsn[26:22];
  assign dx_aluop = DXinsn[6:2];
  assign fd_op    = FDinsn[31:27];
  assign fd_rd    = FDinsn[26:22];
  assign fd_rs    = FDinsn[21:17];
  assign fd_rt    = FDinsn[16:12];

  logic unused_bits;
  assign unused_bits = ^{DXinsn[21:7], DXinsn[1:0], FDinsn[11:0]};

  assign dx_lw  = (dx_op == 5'b01000);
  assign dx_mul = (dx_op == 5'b00000) && (dx_aluop == 5'b00110);
  assign dx_div = (dx_op == 5'b00000) && (dx_aluop == 5'b00111);

  // R-type, addi, lw, sw, bne, blt read rs; only R-type reads rt; bne/blt/jr read rd.
  // sw also reads rd as store data, but that is covered by the dmem bypass.
  assign fd_r      = (fd_op == 5'b00000);
  assign fd_rs_use = fd_r || (fd_op == 5'b00101) || (fd_op == 5'b01000) ||
                     (fd_op == 5'b00111) || (fd_op == 5'b00010) || (fd_op == 5'b00110);
  assign fd_rd_use = (fd_op == 5'b00010) || (fd_op == 5'b00110) || (fd_op == 5'b00100);

  assign load_use = dx_lw && (dx_rd != 5'd0) &&
                    ((fd_rs_use && (fd_rs == dx_rd)) ||
                     (fd_r && (fd_rt == dx_rd)) ||
                     (fd_rd_use && (fd_rd == dx_rd)));

  assign op_exc = is_div_q ? 32'(DIV_EXC) : 32'(MUL_EXC);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    md_result_d = md_result_q;
    md_exc_d    = md_exc_q;
    start       = 1'b0;
    stalled     = 1'b0;
    ctrl_MULT   = 1'b0;
    ctrl_DIV    = 1'b0;
    stall_PC    = 1'b0;
    stall_FD    = 1'b0;
    stall_DX    = 1'b0;
    bubble_DX   = 1'b0;
    bubble_XM   = 1'b0;
    flush_FD    = 1'b0;
    md_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dx_mul || dx_div) begin
          start     = 1'b1;
          ctrl_MULT = dx_mul;
          ctrl_DIV  = dx_div;
          is_div_d  = dx_div;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (multdiv_resultRDY) begin
          md_result_d = multdiv_result;
          md_exc_d    = multdiv_exception ? op_exc : 32'd0;
          state_d     = StDone;
        end else if (cnt_q == CntW'(MD_TIMEOUT - 1)) begin
          md_result_d = 32'd0;
          md_exc_d    = op_exc;
          state_d     = StDone;
        end
      end
      StDone: begin
        md_valid = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    stalled = start || (state_q == StBusy);

    if (stalled) begin
      stall_PC  = 1'b1;
      stall_FD  = 1'b1;
      stall_DX  = 1'b1;
      bubble_XM = 1'b1;
    end else if (branch_taken) begin
      flush_FD  = 1'b1;
      bubble_DX = 1'b1;
    end else if (load_use) begin
      stall_PC  = 1'b1;
      stall_FD  = 1'b1;
      bubble_DX = 1'b1;
    end

    // Outputs must drop in the same cycle reset asserts, not at the next edge.
    if (!reset) begin
      stalled   = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      stall_PC  = 1'b0;
      stall_FD  = 1'b0;
      stall_DX  = 1'b0;
      bubble_DX = 1'b0;
      bubble_XM = 1'b0;
      flush_FD  = 1'b0;
      md_valid  = 1'b0;
    end
  end

  assign busy         = stalled;
  assign md_result    = md_result_q;
  assign md_exception = md_exc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      md_result_q <= 32'd0;
      md_exc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      md_result_q <= md_result_d;
      md_exc_q    <= md_exc_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed vectors push expected outputs,
// a monitor pops and compares once per cycle on the falling edge.
module tb_pipeline_stall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] FDinsn, DXinsn;
  logic        branch_taken, multdiv_resultRDY, multdiv_exception;
  logic [31:0] multdiv_result;
  logic        ctrl_MULT, ctrl_DIV, stall_PC, stall_FD, stall_DX;
  logic        bubble_DX, bubble_XM, flush_FD, md_valid, busy;
  logic [31:0] md_result, md_exception;

  pipeline_stall_controller dut (
    .clock            (clock),
    .reset            (reset),
    .FDinsn           (FDinsn),
    .DXinsn           (DXinsn),
    .branch_taken     (branch_taken),
    .multdiv_resultRDY(multdiv_resultRDY),
    .multdiv_exception(multdiv_exception),
    .multdiv_result   (multdiv_result),
    .ctrl_MULT        (ctrl_MULT),
    .ctrl_DIV         (ctrl_DIV),
    .stall_PC         (stall_PC),
    .stall_FD         (stall_FD),
    .stall_DX         (stall_DX),
    .bubble_DX        (bubble_DX),
    .bubble_XM        (bubble_XM),
    .flush_FD         (flush_FD),
    .md_valid         (md_valid),
    .md_result        (md_result),
    .md_exception     (md_exception),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  localparam logic [9:0] MMult = 10'h001, MDiv = 10'h002, MSpc = 10'h004, MSfd = 10'h008;
  localparam logic [9:0] MSdx = 10'h010, MBdx = 10'h020, MBxm = 10'h040, MFl = 10'h080;
  localparam logic [9:0] MVal = 10'h100, MBusy = 10'h200;
  localparam logic [9:0] MStall = MSpc | MSfd | MSdx | MBxm | MBusy;
  localparam logic [9:0] MLu = MSpc | MSfd | MBdx;

  typedef struct {
    string       name;
    logic [9:0]  bits;
    logic [31:0] res;
    logic [31:0] exc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] exp_exc = 32'd0;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs);
    return {op, rd, rs, 17'd0};
  endfunction

  task automatic step(input string nm, input logic [9:0] b);
    exp_t e;
    e.name = nm;
    e.bits = b;
    e.res  = exp_res;
    e.exc  = exp_exc;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [9:0] act;
      e   = sb.pop_front();
      act = {busy, md_valid, flush_FD, bubble_XM, bubble_DX, stall_DX, stall_FD, stall_PC,
             ctrl_DIV, ctrl_MULT};
      vectors++;
      if (act !== e.bits || md_result !== e.res || md_exception !== e.exc) begin
        miscompares++;
        $display("FAIL %s: got ctl=%b res=%h exc=%h, expected ctl=%b res=%h exc=%h",
                 e.name, act, md_result, md_exception, e.bits, e.res, e.exc);
      end
    end
  end

  initial begin
    logic [31:0] nop, lw3, lw0, add_r3, add_r0, sw3, bne3, mul, dv;
    nop    = 32'd0;
    lw3    = enc_i(5'b01000, 5'd3, 5'd1);
    lw0    = enc_i(5'b01000, 5'd0, 5'd1);
    add_r3 = enc_r(5'd4, 5'd3, 5'd5, 5'b00000);
    add_r0 = enc_r(5'd4, 5'd0, 5'd5, 5'b00000);
    sw3    = enc_i(5'b00111, 5'd3, 5'd6);
    bne3   = enc_i(5'b00010, 5'd3, 5'd7);
    mul    = enc_r(5'd2, 5'd3, 5'd4, 5'b00110);
    dv     = enc_r(5'd2, 5'd3, 5'd4, 5'b00111);

    reset = 1'b0; FDinsn = nop; DXinsn = mul; branch_taken = 1'b0;
    multdiv_resultRDY = 1'b0; multdiv_exception = 1'b0; multdiv_result = 32'd0;
    @(posedge clock);
    #1;
    step("rst_no_start", 10'h0);
    step("rst_no_start2", 10'h0);
    DXinsn = nop; reset = 1'b1;
    step("idle", 10'h0);

    // T1 load-use on rs, then bubble in DX clears it
    DXinsn = lw3; FDinsn = add_r3;
    step("lu_add", MLu);
    DXinsn = nop;
    step("lu_after", 10'h0);
    // T2 sw data-only match and lw $0 never stall; bne reading rd does
    DXinsn = lw3; FDinsn = sw3;
    step("sw_nostall", 10'h0);
    DXinsn = lw0; FDinsn = add_r0;
    step("lw0_nostall", 10'h0);
    DXinsn = lw3; FDinsn = bne3;
    step("lu_bne", MLu);
    // flush wins over load-use
    FDinsn = add_r3; branch_taken = 1'b1;
    step("flush_over_lu", MFl | MBdx);
    branch_taken = 1'b0; DXinsn = nop;
    step("post_flush", 10'h0);

    // T3 mul, RDY 17 cycles after start
    DXinsn = mul;
    step("mul_start", MMult | MStall);
    for (int i = 1; i < 17; i++) step("mul_busy", MStall);
    multdiv_resultRDY = 1'b1; multdiv_result = 32'h30;
    step("mul_rdy", MStall);
    multdiv_resultRDY = 1'b0; multdiv_result = 32'd0;
    exp_res = 32'h30; exp_exc = 32'd0;
    step("mul_done", MVal);
    DXinsn = nop; multdiv_resultRDY = 1'b1; multdiv_result = 32'hdead;
    step("rdy_in_idle", 10'h0);
    multdiv_resultRDY = 1'b0;
    step("rdy_ignored", 10'h0);

    // T4 div with exception, then back-to-back div restarts
    DXinsn = dv;
    step("div_start", MDiv | MStall);
    for (int i = 1; i < 5; i++) step("div_busy", MStall);
    multdiv_resultRDY = 1'b1; multdiv_exception = 1'b1; multdiv_result = 32'h77;
    step("div_rdy", MStall);
    multdiv_resultRDY = 1'b0; multdiv_exception = 1'b0;
    exp_res = 32'h77; exp_exc = 32'd5;
    step("div_exc_done", MVal);
    step("div2_start", MDiv | MStall);
    step("div2_busy", MStall);
    multdiv_resultRDY = 1'b1; multdiv_result = 32'h9;
    step("div2_rdy", MStall);
    multdiv_resultRDY = 1'b0;
    exp_res = 32'h9; exp_exc = 32'd0;
    step("div2_done", MVal);
    DXinsn = nop;
    step("div2_idle", 10'h0);

    // T5 mul timeout
    DXinsn = mul;
    step("to_start", MMult | MStall);
    for (int i = 1; i <= 40; i++) step("to_busy", MStall);
    exp_res = 32'd0; exp_exc = 32'd4;
    step("to_done", MVal);
    DXinsn = nop;
    step("to_idle", 10'h0);

    // T6 reset mid-BUSY, release restarts the mul still in DX
    DXinsn = mul;
    step("r6_start", MMult | MStall);
    for (int i = 1; i < 4; i++) step("r6_busy", MStall);
    reset = 1'b0;
    exp_res = 32'd0; exp_exc = 32'd0;
    step("r6_reset", 10'h0);
    step("r6_reset2", 10'h0);
    reset = 1'b1;
    step("r6_restart", MMult | MStall);
    multdiv_resultRDY = 1'b1; multdiv_result = 32'h5;
    step("r6_rdy", MStall);
    multdiv_resultRDY = 1'b0;
    exp_res = 32'h5;
    step("r6_done", MVal);
    DXinsn = nop;
    step("r6_idle", 10'h0);

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
